// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM state type and RV32I load/store funct3 codes for dmem_lsu
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    ERR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic [15:0]     wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*lane +: 8];
    half_sel = word[16*lane[1] +: 16];

    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = word;
    endcase

    // Only the addressed lane is replaced; the rest of the read word is written back unchanged.
    merged = word;
    case (funct3[1:0])
      2'b00:   merged[8*lane +: 8] = wdata[7:0];
      2'b01:   merged[16*lane[1] +: 16] = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit to a word-wide memory port; LSU_MISALIGN_CHK_EN enables misalignment errors
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state, state_nx;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic            accept;
  logic            bad_f3;
  logic            misalign;
  logic            done;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign done      = (state == LOAD) || (state == STORE) || (state == RMW_WR) || (state == ERR);

  always_comb begin
    if (req_we)
      bad_f3 = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
    else
      bad_f3 = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
  end

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .word      (mem_rdata),
    .lane      (lane_q),
    .funct3    (f3_q),
    .wdata     (mem_wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // mem_we comes from state alone so an asynchronous reset drops it immediately.
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_f3 || misalign)    state_nx = ERR;
          else if (!req_we)          state_nx = LOAD;
          else if (req_funct3 == F3_W) state_nx = STORE;
          else                       state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = IDLE;
      STORE: begin
        mem_we   = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD:  state_nx = RMW_WR;
      RMW_WR: begin
        mem_we   = 1'b1;
        state_nx = IDLE;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q       <= '0;
      lane_q     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= done;
      resp_err   <= (state == ERR);
      if (accept) begin
        f3_q     <= req_funct3;
        lane_q   <= req_addr[1:0];
        mem_addr <= {req_addr[XLEN-1:2], 2'b00};
        if (req_we) mem_wdata <= req_wdata;
      end
      // mem_wdata doubles as the merge buffer between the read and write halves of RMW.
      case (state)
        LOAD:                resp_rdata <= load_data;
        STORE, RMW_WR, ERR:  resp_rdata <= '0;
        RMW_RD:              mem_wdata  <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard bench for dmem_lsu with a word memory model; honours LSU_MISALIGN_CHK_EN
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t er;
  wr_t  ew;

  dmem_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a request or writes memory.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (rsp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1, expected no response (cycle %0d)", cyc);
        end else begin
          er = rsp_q.pop_front();
          check("resp_rdata", resp_rdata, er.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, er.err});
          check("resp_cycle", 32'(cyc), 32'(er.due));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_write: got mem_we=1 addr %h data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          ew = wr_q.pop_front();
          check("mem_addr", mem_addr, ew.addr);
          check("mem_wdata", mem_wdata, ew.data);
          check("write_cycle", 32'(cyc), 32'(ew.due));
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output int t, output logic rv);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL req_ready_timeout: got req_ready=0, expected 1 within 20 cycles");
    end
    rv         = resp_valid;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    t          = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    int t; logic rv;
    send(1'b0, f3, addr, 32'd0, t, rv);
    rsp_q.push_back('{rdata: exp, err: 1'b0, due: t + 2});
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_word);
    int t; logic rv;
    send(1'b1, f3, addr, wdata, t, rv);
    if (f3 == 3'd2) begin
      wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: exp_word, due: t + 1});
      rsp_q.push_back('{rdata: 32'd0, err: 1'b0, due: t + 2});
    end else begin
      wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: exp_word, due: t + 2});
      rsp_q.push_back('{rdata: 32'd0, err: 1'b0, due: t + 3});
    end
  endtask

  task automatic do_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int t; logic rv;
    send(we, f3, addr, 32'h5555_5555, t, rv);
    rsp_q.push_back('{rdata: 32'd0, err: 1'b1, due: t + 2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    logic rv;
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[8'h40] <= 32'h80FF_1234;
    mem[8'hC0] <= 32'h5566_7788;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    do_load(3'd0, 32'h103, 32'hFFFF_FF80);
    do_load(3'd5, 32'h102, 32'h0000_80FF);
    do_load(3'd1, 32'h102, 32'hFFFF_80FF);
    do_load(3'd4, 32'h103, 32'h0000_0080);
    do_load(3'd2, 32'h100, 32'h80FF_1234);
    do_load(3'd0, 32'h100, 32'h0000_0034);
    do_load(3'd1, 32'h100, 32'h0000_1234);

    repeat (3) @(negedge clk);
    mem[8'h40] <= 32'h1122_3344;

    do_store(3'd0, 32'h101, 32'h1234_56AA, 32'h1122_AA44);
    do_store(3'd1, 32'h102, 32'h0000_BEEF, 32'hBEEF_AA44);
    do_load(3'd2, 32'h100, 32'hBEEF_AA44);

    do_store(3'd2, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send(1'b0, 3'd2, 32'h200, 32'd0, t, rv);
    rsp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, due: t + 2});
    check("b2b_accept_with_resp_valid", {31'd0, rv}, 32'd1);

    do_bad(1'b0, 3'd3, 32'h100);
    do_bad(1'b0, 3'd6, 32'h100);
    do_bad(1'b0, 3'd7, 32'h100);
    do_bad(1'b1, 3'd3, 32'h100);
    do_bad(1'b1, 3'd4, 32'h100);

`ifdef LSU_MISALIGN_CHK_EN
    do_bad(1'b0, 3'd2, 32'h202);
    do_bad(1'b0, 3'd1, 32'h101);
    do_bad(1'b1, 3'd1, 32'h103);
`else
    do_load(3'd2, 32'h202, 32'hDEAD_BEEF);
    do_load(3'd1, 32'h101, 32'hFFFF_AA44);
    do_store(3'd1, 32'h103, 32'h0000_1357, 32'h1357_AA44);
`endif

    // Abort an SH while it sits in RMW_RD; nothing may be written or answered.
    repeat (4) @(negedge clk);
    send(1'b1, 3'd1, 32'h302, 32'h0000_CAFE, t, rv);
    reset = 1'b1;
    #1;
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_req_ready_async", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_mem_unchanged", mem[8'hC0], 32'h5566_7788);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);

    check("final_word_100", mem[8'h40],
`ifdef LSU_MISALIGN_CHK_EN
          32'hBEEF_AA44);
`else
          32'h1357_AA44);
`endif
    check("final_word_200", mem[8'h80], 32'hDEAD_BEEF);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
